stream_rr_sched: RTL
====================

Name: stream_rr_sched

Overview:
- Shares one valid/ready data-processing unit (32-bit in/out streams, enable/busy/done control) between NUM_REQ requesters.
- Round-robin burst scheduler: grants one requester at a time, forwards up to MAX_BURST request beats, and routes returned results back to the owner.
- Waits for all outstanding results before re-arbitrating.
- Sits between requester stream ports and the processing unit's slave input and master output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, stream data width
- MAX_BURST, 4, max beats accepted per grant (1..15)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  level; permits new grants
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  one-cycle pulse when a scheduling session ends
- grant  out  NUM_REQ  registered one-hot owner, 0 when none
- req_valid  in  NUM_REQ  per-requester valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester ready
- m_data  out  DATA_WIDTH  to unit input
- m_valid  out  1  to unit input
- m_ready  in  1  from unit input
- s_data  in  DATA_WIDTH  from unit output
- s_valid  in  1  from unit output
- s_ready  out  1  to unit output
- rsp_data  out  DATA_WIDTH  s_data broadcast to all requesters
- rsp_valid  out  NUM_REQ  one-hot, owner only
- rsp_ready  in  NUM_REQ  per-requester result ready

Behaviour:
Reset:
- Single clock clk; reset is synchronous and active-high.
- At reset: state=IDLE; grant=0; busy=0; done=0; burst_cnt=0; outstanding=0; rr_ptr=NUM_REQ-1, so requester 0 wins first.
- All combinational outputs evaluate to 0 with grant=0.
- Reset mid-operation discards outstanding count; the unit shares this reset.

States:
- IDLE: if enable && |req_valid, go to ARB.
- ARB (1 cycle): winner = first set req_valid bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Load grant=one-hot(winner), rr_ptr=winner, burst_cnt=0, then go to SEND. If req_valid dropped to 0 meanwhile, go to DONE with grant=0.
- SEND:
  - m_valid=req_valid[g], m_data=req_data[g], req_ready[g]=m_ready; all other req_ready=0.
  - Beat accepted when m_valid&&m_ready: burst_cnt++, outstanding++.
  - Leave to DRAIN when the accepted beat makes burst_cnt==MAX_BURST, or req_valid[g]==0, or enable==0. A beat accepted in the exit cycle counts.
- DRAIN: m_valid=0, all req_ready=0. When outstanding==0 (checked after this cycle's update):
  - if enable && |req_valid, go to ARB;
  - else go to DONE.
- DONE: done=1 for one cycle, grant=0, then go to IDLE.

Response routing (SEND and DRAIN):
- rsp_valid[g]=s_valid, s_ready=rsp_ready[g], rsp_data=s_data.
- Result accepted when s_valid&&s_ready: outstanding--.
- Simultaneous beat accept and result accept leaves outstanding unchanged.
- s_ready forced 0 when outstanding==0 and no beat is accepted that cycle. A stray result stalls and is not dropped.
- Outside SEND/DRAIN: s_ready=0, rsp_valid=0.

Widths and latency:
- outstanding is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
- burst_cnt has the same width.
- Latency: enable and request sampled in IDLE at edge k; ARB during cycle k+1; first m_valid possible in cycle k+2. Grant switchover costs ≥2 idle cycles (DRAIN exit plus ARB).
- The non-owner requester's valid is ignored; its data must be held by the requester per valid/ready rules.

Test Plan:
- Single requester: req_valid=4'b0001, data 0,10,20,30,40; unit returns data+1 with m_ready=1 → beats 0..30 forwarded (MAX_BURST=4); results 1,11,21,31 on rsp_valid[0]. Second grant to requester 0 forwards 40; result 41. One done pulse after 41 accepted.
- Round-robin fairness: all four requesters valid continuously, MAX_BURST=2 → grant sequence 0001,0010,0100,1000,0001; each grant accepts exactly 2 beats; no grant changes while outstanding≠0.
- Backpressure: m_ready toggling 1,0,0,1 and rsp_ready[g]=0 for 5 cycles → no beat or result lost or duplicated. outstanding peaks at 4. DRAIN holds until all 4 results return.
- Early release and enable drop: requester 2 drops req_valid after 1 beat → DRAIN then ARB picks requester 3. enable deasserted mid-SEND → no further beats; DRAIN completes; done=1 for exactly 1 cycle; busy=0 afterwards.
- Simultaneous accept/return and stray result: beat and result accepted in the same cycle → outstanding unchanged. s_valid=1 in IDLE → s_ready=0; result held, not consumed.
- Reset mid-burst: reset=1 for 1 cycle during SEND with outstanding=2 → next cycle grant=0, busy=0, m_valid=0, state IDLE. Next grant goes to requester 0.

Source files
------------

// File: rtl/stream_rr_sched_if.sv
// Stream bundle between requesters, the scheduler and the shared unit.
// Master is the scheduler side; slave is the requester/unit environment.
interface stream_rr_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         m_data;
    logic                          m_valid;
    logic                          m_ready;
    logic [DATA_WIDTH-1:0]         s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;

    modport master (
        input  req_valid, req_data,
        output req_ready,
        output m_data, m_valid,
        input  m_ready,
        input  s_data, s_valid,
        output s_ready,
        output rsp_data, rsp_valid,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_data,
        input  req_ready,
        input  m_data, m_valid,
        output m_ready,
        output s_data, s_valid,
        input  s_ready,
        input  rsp_data, rsp_valid,
        output rsp_ready
    );
endinterface

// File: rtl/stream_rr_sched.sv
// Round-robin burst scheduler sharing one stream processing unit
// between several requesters, routing results back to the owner.
module stream_rr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               busy,
    output logic               done,
    output logic [NUM_REQ-1:0] grant,
    stream_rr_sched_if.master  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ARB, SEND, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]      outst_q, outst_d;

    logic [IW-1:0] gidx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    int            idx;
    logic          route, beat, res;
    logic          own_valid, own_rsp_ready;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) gidx = IW'(i);
    end

    // Scan starts one past the last winner so every requester gets a turn
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    assign route         = (state_q == SEND) || (state_q == DRAIN);
    assign own_valid     = |(bus.req_valid & grant_q);
    assign own_rsp_ready = |(bus.rsp_ready & grant_q);

    assign bus.m_valid   = (state_q == SEND) && own_valid;
    assign bus.m_data    = (state_q == SEND) ?
        bus.req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.req_ready = (state_q == SEND) ?
        (grant_q & {NUM_REQ{bus.m_ready}}) : '0;
    assign beat          = bus.m_valid && bus.m_ready;

    // A result with nothing in flight is a stray; leave it stalled
    assign bus.s_ready   = route && own_rsp_ready &&
                           ((outst_q != '0) || beat);
    assign res           = bus.s_valid && bus.s_ready;
    assign bus.rsp_valid = route ? (grant_q & {NUM_REQ{bus.s_valid}}) : '0;
    assign bus.rsp_data  = route ? bus.s_data : '0;

    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign done  = (state_q == DONE);
    assign grant = grant_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        outst_d     = outst_q + CW'(beat) - CW'(res);
        unique case (state_q)
            IDLE: begin
                if (enable && |bus.req_valid) state_d = ARB;
            end
            ARB: begin
                grant_d = '0;
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = win_idx;
                    burst_cnt_d      = '0;
                    state_d          = SEND;
                end else begin
                    state_d = DONE;
                end
            end
            SEND: begin
                if (beat) burst_cnt_d = burst_cnt_q + 1'b1;
                if ((beat && burst_cnt_q == CW'(MAX_BURST - 1)) ||
                    !own_valid || !enable)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    grant_d = '0;
                    state_d = (enable && |bus.req_valid) ? ARB : DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            outst_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            outst_q     <= outst_d;
        end
    end
endmodule
